// File: rtl/axi_progmem_wr_pkg.sv
// Shared constants for the program-memory AXI4-Lite write slave: B response codes and FSM encodings.
package axi_progmem_wr_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

endpackage

// File: rtl/axi_progmem_wr_hold.sv
// One-entry holding register for a single AXI channel (AW or W) with a registered ready = !held.
module axi_progmem_wr_hold #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         clear_i,
  output logic         ready_o,
  output logic         held_o,
  output logic [W-1:0] data_o
);

  logic         held_q, held_d;
  logic         ready_q;
  logic [W-1:0] data_q, data_d;
  logic         capture;

  // clear_i only arrives while held, when ready is low, so clear and capture never overlap.
  assign capture = valid_i & ready_q;

  always_comb begin
    held_d = held_q;
    data_d = data_q;
    if (clear_i) held_d = 1'b0;
    if (capture) begin
      held_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_q  <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      held_q  <= held_d;
      ready_q <= ~held_d;
      data_q  <= data_d;
    end
  end

  assign ready_o = ready_q;
  assign held_o  = held_q;
  assign data_o  = data_q;

endmodule

// File: rtl/axi_progmem_wr.sv
// AXI4-Lite write-only slave committing loader words into the program BRAM write port.
// Optional upper-address range check enabled by defining PROGMEM_RANGE_CHECK_EN.
module axi_progmem_wr
  import axi_progmem_wr_pkg::*;
#(
  parameter int MEM_ADDR_SIZE = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_DEPTH     = 65536,
  parameter int WORD_AW       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MEM_ADDR_SIZE-1:0]  axi_awaddr,
  input  logic                      axi_awvalid,
  output logic                      axi_awready,
  input  logic [DATA_WIDTH-1:0]     axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   axi_wstrb,
  input  logic                      axi_wvalid,
  output logic                      axi_wready,
  input  logic                      b_ready,
  output logic                      b_valid,
  output logic [1:0]                b_response,
  output logic                      mem_we,
  output logic [WORD_AW-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_be,
  output logic [1:0]                dbg_state
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int WD_W   = DATA_WIDTH + STRB_W;

  // Handshake rule for AW, W and B: a transfer happens on a posedge where valid and ready are both high;
  // a valid may wait any number of cycles for ready and is never dropped while waiting.

  logic                     aw_held, w_held, hold_clear;
  logic [MEM_ADDR_SIZE-1:0] aw_addr_h;
  logic [WD_W-1:0]          w_bundle_h;
  logic                     range_err;

  axi_progmem_wr_hold #(.W(MEM_ADDR_SIZE)) u_aw_hold (
    .clk     (clk),
    .rst     (rst),
    .valid_i (axi_awvalid),
    .data_i  (axi_awaddr),
    .clear_i (hold_clear),
    .ready_o (axi_awready),
    .held_o  (aw_held),
    .data_o  (aw_addr_h)
  );

  axi_progmem_wr_hold #(.W(WD_W)) u_w_hold (
    .clk     (clk),
    .rst     (rst),
    .valid_i (axi_wvalid),
    .data_i  ({axi_wstrb, axi_wdata}),
    .clear_i (hold_clear),
    .ready_o (axi_wready),
    .held_o  (w_held),
    .data_o  (w_bundle_h)
  );

`ifdef PROGMEM_RANGE_CHECK_EN
  assign range_err = |aw_addr_h[MEM_ADDR_SIZE-1:WORD_AW+2];
  logic unused_addr_bits;
  assign unused_addr_bits = ^aw_addr_h[1:0];
`else
  // Upper address bits are ignored; the word address wraps modulo MEM_DEPTH.
  assign range_err = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{aw_addr_h[MEM_ADDR_SIZE-1:WORD_AW+2], aw_addr_h[1:0]};
`endif

  logic [1:0]              state_q, state_d;
  logic                    mem_we_q, mem_we_d;
  logic [WORD_AW-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]       mem_be_q, mem_be_d;
  logic                    b_valid_q, b_valid_d;
  logic [1:0]              b_resp_q, b_resp_d;
  logic                    err_q, err_d;

  always_comb begin
    state_d     = state_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    b_valid_d   = b_valid_q;
    b_resp_d    = b_resp_q;
    err_d       = err_q;
    hold_clear  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (aw_held && w_held) begin
          state_d     = ST_WRITE;
          hold_clear  = 1'b1;
          mem_we_d    = ~range_err;
          mem_addr_d  = aw_addr_h[WORD_AW+1:2] & WORD_AW'(MEM_DEPTH - 1);
          mem_wdata_d = w_bundle_h[DATA_WIDTH-1:0];
          mem_be_d    = w_bundle_h[WD_W-1:DATA_WIDTH];
          err_d       = range_err;
        end
      end
      ST_WRITE: begin
        state_d   = ST_RESP;
        b_valid_d = 1'b1;
        b_resp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      ST_RESP: begin
        if (b_ready) begin
          state_d   = ST_IDLE;
          b_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      b_valid_q   <= 1'b0;
      b_resp_q    <= RESP_OKAY;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      b_valid_q   <= b_valid_d;
      b_resp_q    <= b_resp_d;
      err_q       <= err_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;
  assign b_valid    = b_valid_q;
  assign b_response = b_resp_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_axi_progmem_wr.sv
// Self-checking bench for axi_progmem_wr: timestamp-based transaction model plus directed literal checks.
module tb_axi_progmem_wr;

  logic        clk;
  logic        rst;
  logic [31:0] axi_awaddr;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready;
  logic        b_ready;
  logic        b_valid;
  logic [1:0]  b_response;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [1:0]  dbg_state;

  axi_progmem_wr dut (
    .clk         (clk),
    .rst         (rst),
    .axi_awaddr  (axi_awaddr),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .b_ready     (b_ready),
    .b_valid     (b_valid),
    .b_response  (b_response),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset / edge counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int edge_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) edge_cnt <= 0;
    else      edge_cnt <= edge_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  // Pairs the i-th accepted AW with the i-th accepted W. A pair is written on the edge after both
  // halves were accepted and the previous response was taken; its B is offered from the edge after that.
  logic [31:0] aw_q[$];
  int          aw_t[$];
  logic [31:0] exp_q[$];
  logic [3:0]  be_q[$];
  int          w_t[$];
  bit          outstanding;
  int          t_wr, last_b;
  logic [1:0]  cur_resp;
  bit          nxt_aw, nxt_w, nxt_b;
  logic [31:0] nxt_aw_addr, nxt_w_data;
  logic [3:0]  nxt_w_be;

  function automatic bit addr_err(input logic [31:0] a);
`ifdef PROGMEM_RANGE_CHECK_EN
    return a[31:18] != 14'd0;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    int k, tmax;
    bit exp_we, exp_awr, exp_wr, exp_bv, err;
    logic [31:0] a, d;
    logic [3:0] be;
    if (!rst) begin
      aw_q.delete(); aw_t.delete(); exp_q.delete(); be_q.delete(); w_t.delete();
      outstanding = 0; last_b = 0; t_wr = 0;
      nxt_aw = 0; nxt_w = 0; nxt_b = 0;
      chk("rst_awready", axi_awready, 0);
      chk("rst_wready", axi_wready, 0);
      chk("rst_bvalid", b_valid, 0);
      chk("rst_bresp", b_response, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_be", mem_be, 0);
    end else begin
      k = edge_cnt;
      if (nxt_aw) begin aw_q.push_back(nxt_aw_addr); aw_t.push_back(k); end
      if (nxt_w) begin exp_q.push_back(nxt_w_data); be_q.push_back(nxt_w_be); w_t.push_back(k); end
      if (nxt_b) begin outstanding = 0; last_b = k; end
      nxt_aw = 0; nxt_w = 0; nxt_b = 0;
      exp_we = 0; a = 0; d = 0; be = 0;
      if (!outstanding && aw_q.size() > 0 && exp_q.size() > 0) begin
        tmax = aw_t[0];
        if (w_t[0] > tmax) tmax = w_t[0];
        if (last_b > tmax) tmax = last_b;
        if (tmax + 1 <= k) begin
          a = aw_q.pop_front(); void'(aw_t.pop_front());
          d = exp_q.pop_front(); be = be_q.pop_front(); void'(w_t.pop_front());
          err = addr_err(a);
          outstanding = 1; t_wr = k;
          exp_we = !err;
          cur_resp = err ? 2'b10 : 2'b00;
        end
      end
      exp_awr = (k >= 1) && aw_q.size() == 0;
      exp_wr  = (k >= 1) && exp_q.size() == 0;
      exp_bv  = outstanding && (k >= t_wr + 1);
      chk("m_awready", axi_awready, exp_awr);
      chk("m_wready", axi_wready, exp_wr);
      chk("m_mem_we", mem_we, exp_we);
      if (exp_we) begin
        chk("m_mem_addr", mem_addr, a[17:2]);
        chk("m_mem_wdata", mem_wdata, d);
        chk("m_mem_be", mem_be, be);
      end
      chk("m_bvalid", b_valid, exp_bv);
      if (exp_bv) chk("m_bresp", b_response, cur_resp);
      if (axi_awvalid && exp_awr) begin nxt_aw = 1; nxt_aw_addr = axi_awaddr; end
      if (axi_wvalid && exp_wr) begin nxt_w = 1; nxt_w_data = axi_wdata; nxt_w_be = axi_wstrb; end
      if (b_ready && exp_bv) nxt_b = 1;
    end
  end

  // ---------------- driver tasks ----------------
  int aw_edge, w_edge;

  task automatic send_aw(input logic [31:0] addr);
    bit ok = 0;
    @(posedge clk); #1;
    axi_awaddr = addr; axi_awvalid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (axi_awready) begin ok = 1; break; end
    end
    chk("aw_handshake_timeout", ok, 1);
    @(posedge clk); #1;
    aw_edge = edge_cnt;
    axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    bit ok = 0;
    @(posedge clk); #1;
    axi_wdata = data; axi_wstrb = strb; axi_wvalid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (axi_wready) begin ok = 1; break; end
    end
    chk("w_handshake_timeout", ok, 1);
    @(posedge clk); #1;
    w_edge = edge_cnt;
    axi_wvalid = 1'b0;
  endtask

  task automatic wait_we(output int e);
    bit ok = 0;
    e = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_we) begin ok = 1; e = edge_cnt; break; end
    end
    chk("mem_we_timeout", ok, 1);
  endtask

  task automatic wait_bvalid(output int e);
    bit ok = 0;
    e = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b_valid) begin ok = 1; e = edge_cnt; break; end
    end
    chk("bvalid_timeout", ok, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int we_e, b_e, cnt;
    logic [1:0] seen_resp;
    logic [15:0] seen_addr;
    rst = 1'b1;
    axi_awaddr = '0; axi_awvalid = 1'b0;
    axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 1'b0;
    b_ready = 1'b0;
    #1 rst = 1'b0;

    // 1: reset with random valids, then release
    repeat (6) begin
      @(posedge clk); #1;
      axi_awvalid = 1'($urandom_range(0, 1));
      axi_wvalid  = 1'($urandom_range(0, 1));
      b_ready     = 1'($urandom_range(0, 1));
      axi_awaddr  = $urandom_range(0, 32'hFFFF);
      axi_wdata   = $urandom_range(0, 32'hFFFF);
    end
    chk("t1_state_idle", dbg_state, 0);
    @(posedge clk); #1;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; b_ready = 1'b1;
    rst = 1'b1;
    chk("t1_awready_before_edge", axi_awready, 0);
    @(posedge clk); #1;
    chk("t1_awready_up", axi_awready, 1);
    chk("t1_wready_up", axi_wready, 1);

    // 2: simultaneous AW/W
    fork
      send_aw(32'h0000_0010);
      send_w(32'hDEAD_BEEF, 4'hF);
    join
    chk("t2_same_edge", aw_edge, w_edge);
    wait_we(we_e);
    chk("t2_mem_addr", mem_addr, 16'h0004);
    chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t2_mem_be", mem_be, 4'hF);
    chk("t2_we_latency", we_e - aw_edge, 1);
    wait_bvalid(b_e);
    chk("t2_b_latency", b_e - aw_edge, 2);
    chk("t2_bresp", b_response, 2'b00);
    idle(3);

    // 3: W five cycles ahead of AW
    send_w(32'h1234_5678, 4'hF);
    repeat (5) begin
      @(negedge clk);
      chk("t3_wready_low", axi_wready, 0);
      chk("t3_no_we", mem_we, 0);
    end
    send_aw(32'h0000_0100);
    wait_we(we_e);
    chk("t3_mem_addr", mem_addr, 16'h0040);
    chk("t3_mem_wdata", mem_wdata, 32'h1234_5678);
    chk("t3_we_after_aw", we_e - aw_edge, 1);
    idle(4);

    // 4: b_ready held low, next transaction captured during RESP
    b_ready = 1'b0;
    fork
      send_aw(32'h0000_0200);
      send_w(32'h1111_2222, 4'h3);
    join
    wait_bvalid(b_e);
    fork
      send_aw(32'h0000_0204);
      send_w(32'h3333_4444, 4'hC);
    join
    repeat (10) begin
      @(negedge clk);
      chk("t4_bvalid_held", b_valid, 1);
      chk("t4_bresp_stable", b_response, 2'b00);
      chk("t4_no_second_we", mem_we, 0);
    end
    @(posedge clk); #1;
    b_ready = 1'b1;
    b_e = edge_cnt + 1;
    wait_we(we_e);
    chk("t4_we_after_b", we_e - b_e, 1);
    chk("t4_mem_addr", mem_addr, 16'h0081);
    chk("t4_mem_wdata", mem_wdata, 32'h3333_4444);
    chk("t4_mem_be", mem_be, 4'hC);
    idle(4);

    // 5: address above the BRAM window
    fork
      send_aw(32'h0004_0000);
      send_w(32'hCAFE_F00D, 4'hF);
    join
    cnt = 0; seen_resp = 2'b11; seen_addr = 16'hFFFF;
    repeat (6) begin
      @(negedge clk);
      if (mem_we) begin cnt++; seen_addr = mem_addr; end
      if (b_valid) seen_resp = b_response;
    end
`ifdef PROGMEM_RANGE_CHECK_EN
    chk("t5_we_count", cnt, 0);
    chk("t5_bresp_slverr", seen_resp, 2'b10);
`else
    chk("t5_we_count", cnt, 1);
    chk("t5_wrap_addr", seen_addr, 16'h0000);
    chk("t5_bresp_okay", seen_resp, 2'b00);
`endif
    idle(2);

    // 6: reset while in WRITE
    fork
      send_aw(32'h0000_0300);
      send_w(32'h5555_AAAA, 4'hF);
    join
    wait_we(we_e);
    #2 rst = 1'b0;
    #1;
    chk("t6_we_dropped", mem_we, 0);
    chk("t6_bvalid_dropped", b_valid, 0);
    chk("t6_state_idle", dbg_state, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (b_valid || mem_we) cnt++;
    end
    chk("t6_no_late_b", cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
